// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI encodings and defaults
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Mode constants are {CKP, CPH}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - flop-chain synchronizer for one asynchronous input
module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_receptor.sv
// rtl/spi_receptor.sv - oversampling SPI responder, all four CKP/CPH modes
module spi_receptor
  import spi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] DATAINPUT,
  output logic             MISO,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             VALID,
  output logic             BUSY
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic sck_s, cs_s, mosi_s;
  logic sck_prev_q, cs_prev_q;
  logic sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e, cs_fall;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_q, rx_d, rx_next;
  logic [WIDTH-1:0] tx_q, tx_d, tx_load;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             miso_q, miso_d;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck
    (.clk_i(CLK), .rst_ni(RESET), .d_i(SCK), .q_o(sck_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs
    (.clk_i(CLK), .rst_ni(RESET), .d_i(CS), .q_o(cs_s));
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi
    (.clk_i(CLK), .rst_ni(RESET), .d_i(MOSI), .q_o(mosi_s));

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign lead_e   = CKP ? sck_fall : sck_rise;
  assign trail_e  = CKP ? sck_rise : sck_fall;
  assign sample_e = CPH ? trail_e : lead_e;
  assign shift_e  = CPH ? lead_e : trail_e;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign rx_next = (rx_q << 1) | WIDTH'(mosi_s);
  // With CPH=0 the MSB is presented at frame start, so tx holds the remaining bits
  assign tx_load = CPH ? DATAINPUT : (DATAINPUT << 1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      dout_q     <= '0;
      miso_q     <= 1'b0;
    end else begin
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      dout_q     <= dout_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    dout_d  = dout_q;
    miso_d  = miso_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d    = tx_load;
          miso_d  = CPH ? 1'b0 : DATAINPUT[WIDTH-1];
        end
      end
      SHIFT: begin
        // A final sample coinciding with CS release still completes the frame
        if (sample_e && cnt_q == LAST) begin
          rx_d    = rx_next;
          dout_d  = rx_next;
          cnt_d   = cnt_q + 1'b1;
          state_d = DONE;
        end else if (cs_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else if (sample_e) begin
          rx_d  = rx_next;
          cnt_d = cnt_q + 1'b1;
        end else if (shift_e && (CPH || cnt_q != '0)) begin
          miso_d = tx_q[WIDTH-1];
          tx_d   = tx_q << 1;
        end
      end
      DONE: begin
        cnt_d = '0;
        tx_d  = tx_load;
        if (!CPH) miso_d = DATAINPUT[WIDTH-1];
        if (cs_s) begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO    = miso_q;
  assign DATAOUT = dout_q;
  assign VALID   = (state_q == DONE);
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_receptor.sv
// tb/tb_spi_receptor.sv - directed scoreboard bench for spi_receptor
module tb_spi_receptor;
  import spi_pkg::*;

  localparam int H = 6;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CKP = 1'b0, CPH = 1'b0, SCK = 1'b0, CS = 1'b1, MOSI = 1'b0;
  logic [7:0] DATAINPUT = 8'h00;
  logic       MISO, VALID, BUSY;
  logic [7:0] DATAOUT;

  int         checks = 0, passes = 0, valid_cnt = 0, v0 = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_byte;
  logic       unstable, busy_seen, miso_seen;

  always #5 CLK = ~CLK;

  spi_receptor #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
    .MOSI(MOSI), .DATAINPUT(DATAINPUT), .MISO(MISO), .DATAOUT(DATAOUT),
    .VALID(VALID), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("dataout", {24'd0, DATAOUT}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_mode(input logic [1:0] m);
    {CKP, CPH} = m;
    SCK = m[1];
    wait_cyc(H);
  endtask

  task automatic sample_miso();
    logic prev;
    wait_cyc(H - 1);
    prev = MISO;
    @(negedge CLK);
    if (MISO !== prev) unstable = 1'b1;
    m_byte = {m_byte[6:0], MISO};
  endtask

  task automatic xfer_bit(input logic b);
    if (!CPH) begin
      MOSI = b;
      sample_miso();
      SCK = ~SCK;
      wait_cyc(H);
      SCK = ~SCK;
    end else begin
      SCK = ~SCK;
      MOSI = b;
      sample_miso();
      SCK = ~SCK;
      wait_cyc(H);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] d, input int lo, input int hi);
    for (int i = lo; i < hi; i++) xfer_bit(d[7-i]);
  endtask

  task automatic frame(input logic [7:0] d);
    m_byte = 8'h00;
    unstable = 1'b0;
    CS = 1'b0;
    wait_cyc(H);
    xfer_bits(d, 0, 8);
    CS = 1'b1;
    wait_cyc(H);
  endtask

  initial begin
    wait_cyc(3);
    check("rst_miso", MISO, 0);
    check("rst_dataout", DATAOUT, 0);
    check("rst_valid", VALID, 0);
    check("rst_busy", BUSY, 0);
    RESET = 1'b1;
    wait_cyc(2);

    // Mode 0 single frame
    set_mode(MODE0);
    DATAINPUT = 8'h3C;
    exp_q.push_back(8'hA5);
    v0 = valid_cnt;
    m_byte = 8'h00;
    unstable = 1'b0;
    CS = 1'b0;
    wait_cyc(H);
    check("busy_in_frame", BUSY, 1);
    xfer_bits(8'hA5, 0, 8);
    CS = 1'b1;
    wait_cyc(H);
    check("m0_miso_word", m_byte, 8'h3C);
    check("m0_miso_stable", unstable, 0);
    check("m0_valid_count", valid_cnt - v0, 1);

    // Modes 1..3, all-ones and all-zeros
    DATAINPUT = 8'hFF;
    v0 = valid_cnt;
    for (int mi = 1; mi < 4; mi++) begin
      set_mode(mi[1:0]);
      exp_q.push_back(8'hFF);
      frame(8'hFF);
      check("mode_miso_ff", m_byte, 8'hFF);
      check("mode_stable_ff", unstable, 0);
      exp_q.push_back(8'h00);
      frame(8'h00);
      check("mode_miso_00", m_byte, 8'hFF);
      check("mode_stable_00", unstable, 0);
    end
    check("modes_valid_count", valid_cnt - v0, 6);

    // Back-to-back frames with DATAINPUT changed mid-frame
    set_mode(MODE0);
    DATAINPUT = 8'h5A;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    v0 = valid_cnt;
    m_byte = 8'h00;
    CS = 1'b0;
    wait_cyc(H);
    xfer_bits(8'h12, 0, 3);
    DATAINPUT = 8'h96;
    xfer_bits(8'h12, 3, 8);
    check("b2b_miso_first", m_byte, 8'h5A);
    m_byte = 8'h00;
    xfer_bits(8'h34, 0, 8);
    check("b2b_miso_second", m_byte, 8'h96);
    CS = 1'b1;
    wait_cyc(H);
    check("b2b_valid_count", valid_cnt - v0, 2);

    // Abort after 5 SCK pulses
    v0 = valid_cnt;
    CS = 1'b0;
    wait_cyc(H);
    xfer_bits(8'hE7, 0, 5);
    CS = 1'b1;
    wait_cyc(3);
    check("abort_busy", BUSY, 0);
    check("abort_miso", MISO, 0);
    wait_cyc(H);
    check("abort_no_valid", valid_cnt - v0, 0);
    check("abort_dataout_held", DATAOUT, 8'h34);

    // Reset mid-frame, then a clean frame
    set_mode(MODE1);
    DATAINPUT = 8'hFF;
    CS = 1'b0;
    wait_cyc(H);
    xfer_bits(8'h77, 0, 3);
    RESET = 1'b0;
    #1;
    check("midrst_miso", MISO, 0);
    check("midrst_dataout", DATAOUT, 0);
    check("midrst_valid", VALID, 0);
    check("midrst_busy", BUSY, 0);
    CS = 1'b1;
    SCK = CKP;
    wait_cyc(3);
    RESET = 1'b1;
    wait_cyc(H);
    v0 = valid_cnt;
    exp_q.push_back(8'hC3);
    frame(8'hC3);
    check("postrst_dataout", DATAOUT, 8'hC3);
    check("postrst_miso_word", m_byte, 8'hFF);
    check("postrst_valid_count", valid_cnt - v0, 1);

    // SCK activity with CS high
    v0 = valid_cnt;
    busy_seen = 1'b0;
    miso_seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      SCK = ~SCK;
      repeat (H) begin
        @(negedge CLK);
        busy_seen = busy_seen | BUSY;
        miso_seen = miso_seen | MISO;
      end
    end
    check("cshigh_no_valid", valid_cnt - v0, 0);
    check("cshigh_busy", busy_seen, 0);
    check("cshigh_miso", miso_seen, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
